// File: rtl/pic_pkg.sv
// Shared definitions for the cascade slave responder: FSM encoding,
// acknowledge timing constants and the ISR one-hot helper.
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK2 = 2'd3
  } pic_state_e;

  // A GAP that lasts this many cycles without a second INTA fall is abandoned
  localparam logic [7:0] GAP_TIMEOUT = 8'd255;
  localparam int         INTA_PULSES = 2;

  function automatic logic [7:0] irq_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Two-flop synchroniser for an active-low strobe followed by a registered
// edge detector producing single-cycle fall/rise pulses.
module pic_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s3   <= 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      fall <= s3 & ~s2;
      rise <= ~s3 & s2;
    end
  end

endmodule

// File: rtl/cascade_slave_responder.sv
// Slave-side responder for a cascaded interrupt controller: tracks the two
// INTA pulses, returns the vector when addressed and drives ISR pulses.
module cascade_slave_responder
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INTA_N,
  input  logic [2:0] CAS,
  input  logic       SP_EN,
  input  logic [2:0] slave_id,
  input  logic       int_pending,
  input  logic [2:0] highest_irq,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic [7:0] isr_set,
  output logic [7:0] isr_clr,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  pic_state_e state;
  pic_state_e next_state;

  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] cas_m;
  logic [2:0] cas_s;

  logic       sel;
  logic [2:0] irq_l;
  logic [7:0] cnt;

  logic       sel_n;
  logic [2:0] irq_n;
  logic [7:0] cnt_n;
  logic       timeout_n;
  logic       oe_n;
  logic [7:0] dout_n;
  logic [7:0] set_n;
  logic [7:0] clr_n;

  pic_sync_edge u_inta_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (INTA_N),
    .fall     (inta_fall),
    .rise     (inta_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cas_m <= 3'd0;
      cas_s <= 3'd0;
    end else begin
      cas_m <= CAS;
      cas_s <= cas_m;
    end
  end

  // State register, with the datapath and all outputs registered alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sel         <= 1'b0;
      irq_l       <= 3'd0;
      cnt         <= 8'd0;
      timeout_err <= 1'b0;
      D_OE        <= 1'b0;
      D_OUT       <= 8'h00;
      isr_set     <= 8'h00;
      isr_clr     <= 8'h00;
    end else begin
      state       <= next_state;
      sel         <= sel_n;
      irq_l       <= irq_n;
      cnt         <= cnt_n;
      timeout_err <= timeout_n;
      D_OE        <= oe_n;
      D_OUT       <= dout_n;
      isr_set     <= set_n;
      isr_clr     <= clr_n;
    end
  end

  always_comb begin
    next_state = state;
    if (SP_EN) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (inta_fall) next_state = ST_ACK1;
        ST_ACK1: if (inta_rise) next_state = ST_GAP;
        ST_GAP: begin
          if (inta_fall)               next_state = ST_ACK2;
          else if (cnt == GAP_TIMEOUT) next_state = ST_IDLE;
        end
        ST_ACK2: if (inta_rise) next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Selection and irq index are frozen at the first fall so later changes
  // on CAS or the priority resolver cannot disturb the second pulse.
  always_comb begin
    sel_n     = sel;
    irq_n     = irq_l;
    cnt_n     = cnt;
    timeout_n = timeout_err;
    oe_n      = D_OE;
    set_n     = 8'h00;
    clr_n     = 8'h00;
    if (SP_EN) begin
      sel_n = 1'b0;
      oe_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inta_fall) begin
            sel_n     = (cas_s == slave_id) && int_pending;
            irq_n     = highest_irq;
            timeout_n = 1'b0;
            if (sel_n) set_n = irq_onehot(highest_irq);
          end
        end
        ST_ACK1: begin
          if (inta_rise) cnt_n = 8'd0;
        end
        ST_GAP: begin
          cnt_n = cnt + 8'd1;
          if (inta_fall) begin
            oe_n = sel;
          end else if (cnt == GAP_TIMEOUT) begin
            timeout_n = 1'b1;
            sel_n     = 1'b0;
          end
        end
        ST_ACK2: begin
          if (inta_rise) begin
            oe_n  = 1'b0;
            sel_n = 1'b0;
            if (sel && aeoi) clr_n = irq_onehot(irq_l);
          end
        end
        default: begin
          sel_n = 1'b0;
          oe_n  = 1'b0;
        end
      endcase
    end
    dout_n = oe_n ? {vector_base, irq_n} : 8'h00;
  end

  assign state_dbg = state;

endmodule
